// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Parametrised sequential shift-add multiplier. Each clock adds one partial
// product into a 2*WIDTH-bit accumulator, so the adder width stays at
// 2*WIDTH no matter how many iterations are needed. Signed operands are
// converted to magnitudes at capture time and the sign is reapplied in a
// single fix-up cycle at the end.
//
// Parameters:
//   WIDTH        operand width in bits (2..32); the product is 2*WIDTH bits
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request a multiply; only looked at while busy=0
//   signed_mode  1 = two's-complement operands/product, 0 = unsigned
//   a            multiplicand, captured with start
//   b            multiplier, captured with start
//   busy         high from the capture edge until the result edge
//   done         one-cycle pulse when result is updated
//   result       product, held stable until the next done
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  // Counter must be able to hold WIDTH-1 (the last iteration index).
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_C   = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P   = (2*WIDTH)'(1);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic               neg_next;

  // Operand magnitudes for the capture edge. The most negative value maps
  // to 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  always_comb begin
    amag     = a;
    bmag     = b;
    neg_next = 1'b0;
    if (signed_mode) begin
      if (a[WIDTH-1]) amag = ~a + ONE_W;
      if (b[WIDTH-1]) bmag = ~b + ONE_W;
      neg_next = a[WIDTH-1] ^ b[WIDTH-1];
    end
  end

  // Control and datapath. done defaults low so it only pulses in the
  // cycle after FIX; result is only written in FIX or by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !busy) begin
            mcand  <= {{WIDTH{1'b0}}, amag};
            mplier <= bmag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= neg_next;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + ONE_C;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          result <= neg ? (~acc + ONE_P) : acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Self-checking bench for seq_multiplier. Three instances (WIDTH = 4, 8, 16)
// share one clock and reset. Expected products come from plain integer
// arithmetic on sign-extended operands, and the WIDTH=4 unsigned results are
// also compared against an AND-array partial-product sum, standing in for
// the old combinational array multiplier. Inputs are driven and outputs
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk;
  logic        rst;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  result4;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] result16;

  int errors;
  int checks;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .result(result4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .result(result16)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural product modulo 2^(2w), operands sign-extended in signed mode
  function automatic longint unsigned model_mul(longint unsigned av, longint unsigned bv,
                                                bit sm, int w);
    longint sa;
    longint sb;
    longint p;
    longint unsigned mask;
    sa = longint'(av);
    sb = longint'(bv);
    if (sm) begin
      if (av[w-1]) sa = sa - (longint'(1) << w);
      if (bv[w-1]) sb = sb - (longint'(1) << w);
    end
    p    = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Unsigned 4x4 product as a sum of ANDed, shifted partial-product rows
  function automatic logic [7:0] array_mul4(logic [3:0] x, logic [3:0] y);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 4; i++)
      s = s + ({4'd0, x & {4{y[i]}}} << i);
    return s;
  endfunction

  // Drive one start pulse; returns at the falling edge after the capture
  // edge with the operand inputs scrambled to show they are not re-read.
  task automatic start_op4(input logic [3:0] x, input logic [3:0] y, input logic sm);
    @(negedge clk);
    a4 = x; b4 = y; sm4 = sm; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
  endtask

  // Count falling edges until done4, tallying busy samples along the way
  task automatic wait_done4(output int lat, output int busy_cycles, output bit ok);
    lat = 0; busy_cycles = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy4) busy_cycles++;
      @(negedge clk);
      lat++;
      if (done4) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done8(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (done8) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done16(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      lat++;
      if (done16) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, done4, result4} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_w4 busy/done/result got %b/%b/%h need 0/0/00", busy4, done4, result4);
    end
    checks++;
    if ({busy8, done8, result8} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_w8 busy/done/result got %b/%b/%h need 0/0/0000", busy8, done8, result8);
    end
    checks++;
    if ({busy16, done16, result16} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_w16 busy/done/result got %b/%b/%h need 0/0/0", busy16, done16, result16);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_max();
    int lat, bc;
    bit ok;
    start_op4(4'd15, 4'd15, 1'b0);
    wait_done4(lat, bc, ok);
    checks++;
    if (!ok || result4 !== 8'hE1) begin
      errors++;
      $display("[TB] FAIL umax_result got %h (done seen %0d) need e1", result4, ok);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("[TB] FAIL umax_latency got %0d need 5", lat);
    end
    checks++;
    if (bc !== 5 || busy4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL umax_busy cycles got %0d (busy at done %b) need 5 (0)", bc, busy4);
    end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL umax_done_width got done=%b one cycle later need 0", done4);
    end
  endtask

  task automatic test_signed_extremes();
    int lat, bc;
    bit ok;
    start_op4(4'h8, 4'h8, 1'b1);
    wait_done4(lat, bc, ok);
    checks++;
    if (!ok || result4 !== 8'h40) begin
      errors++;
      $display("[TB] FAIL signed_min_sq got %h need 40", result4);
    end
    start_op4(4'hD, 4'h5, 1'b1);
    wait_done4(lat, bc, ok);
    checks++;
    if (!ok || result4 !== 8'hF1 || lat !== 5) begin
      errors++;
      $display("[TB] FAIL signed_neg got %h lat %0d need f1 lat 5", result4, lat);
    end
  endtask

  task automatic test_handshake();
    int lat, lat2;
    bit ok;
    start_op4(4'd3, 4'd4, 1'b0);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (lat == 1) begin a4 = 4'd7; b4 = 4'd7; start4 = 1'b1; end
      if (lat == 2) start4 = 1'b0;
      @(negedge clk);
      lat++;
      if (done4) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || result4 !== 8'd12 || lat !== 5) begin
      errors++;
      $display("[TB] FAIL hs_first got %0d lat %0d need 12 lat 5", result4, lat);
    end
    // start during the done cycle must be accepted
    a4 = 4'd2; b4 = 4'd9; sm4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat2 = 1;
    checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hs_accept done/busy got %b/%b need 0/1", done4, busy4);
    end
    @(negedge clk); lat2++;
    checks++;
    if (result4 !== 8'd12) begin
      errors++;
      $display("[TB] FAIL hs_result_hold during run got %0d need 12", result4);
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done4) begin ok = 1'b1; break; end
      @(negedge clk);
      lat2++;
    end
    checks++;
    if (!ok || result4 !== 8'd18 || lat2 !== 6) begin
      errors++;
      $display("[TB] FAIL hs_second got %0d spacing %0d need 18 spacing 6", result4, lat2);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, bc, seen;
    bit ok;
    start_op4(4'd9, 4'd9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy4, done4, result4} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset busy/done/result got %b/%b/%0d need 0/0/0", busy4, done4, result4);
    end
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done4) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL midrun_no_done got %0d done pulses need 0", seen);
    end
    // reset and start together: reset wins
    a4 = 4'd5; b4 = 4'd5; start4 = 1'b1; rst = 1'b1;
    @(negedge clk);
    start4 = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_start_drop busy got %b need 0", busy4);
    end
    start_op4(4'd6, 4'd7, 1'b0);
    wait_done4(lat, bc, ok);
    checks++;
    if (!ok || result4 !== 8'd42) begin
      errors++;
      $display("[TB] FAIL midrun_next got %0d need 42", result4);
    end
  endtask

  task automatic test_exhaustive4();
    int lat, bc;
    bit ok;
    logic [7:0] exp4;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          start_op4(4'(x), 4'(y), 1'(s));
          wait_done4(lat, bc, ok);
          exp4 = 8'(model_mul(longint'(x), longint'(y), 1'(s), 4));
          checks++;
          if (!ok || result4 !== exp4 || lat !== 5) begin
            errors++;
            $display("[TB] FAIL sweep4 s=%0d a=%0d b=%0d got %h lat %0d need %h lat 5",
                     s, x, y, result4, lat, exp4);
          end
          if (s == 0) begin
            checks++;
            if (result4 !== array_mul4(4'(x), 4'(y))) begin
              errors++;
              $display("[TB] FAIL array4 a=%0d b=%0d got %h need %h",
                       x, y, result4, array_mul4(4'(x), 4'(y)));
            end
          end
        end
      end
    end
  endtask

  task automatic test_random8();
    int lat;
    bit ok;
    logic [7:0]  x, y;
    logic        sm;
    logic [15:0] exp;
    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom); y = 8'($urandom); sm = 1'($urandom);
      if (n == 0) begin x = 8'h80; y = 8'h80; sm = 1'b1; end
      if (n == 1) begin x = 8'hFF; y = 8'hFF; sm = 1'b0; end
      if (n == 2) begin x = 8'h00; y = 8'hFF; sm = 1'b1; end
      if (n == 3) begin x = 8'h80; y = 8'h7F; sm = 1'b1; end
      @(negedge clk);
      a8 = x; b8 = y; sm8 = sm; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      wait_done8(lat, ok);
      exp = 16'(model_mul(64'(x), 64'(y), sm, 8));
      checks++;
      if (!ok || result8 !== exp || lat !== 9) begin
        errors++;
        $display("[TB] FAIL rand8 s=%0d a=%h b=%h got %h lat %0d need %h lat 9",
                 sm, x, y, result8, lat, exp);
      end
    end
  endtask

  task automatic test_random16();
    int lat;
    bit ok;
    logic [15:0] x, y;
    logic        sm;
    logic [31:0] exp;
    for (int n = 0; n < 40; n++) begin
      x = 16'($urandom); y = 16'($urandom); sm = 1'($urandom);
      if (n == 0) begin x = 16'h8000; y = 16'h8000; sm = 1'b1; end
      if (n == 1) begin x = 16'hFFFF; y = 16'hFFFF; sm = 1'b0; end
      if (n == 2) begin x = 16'hFFFF; y = 16'h0001; sm = 1'b1; end
      @(negedge clk);
      a16 = x; b16 = y; sm16 = sm; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      wait_done16(lat, ok);
      exp = 32'(model_mul(64'(x), 64'(y), sm, 16));
      checks++;
      if (!ok || result16 !== exp || lat !== 17) begin
        errors++;
        $display("[TB] FAIL rand16 s=%0d a=%h b=%h got %h lat %0d need %h lat 17",
                 sm, x, y, result16, lat, exp);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start4 = 1'b0;  sm4 = 1'b0;  a4 = '0;  b4 = '0;
    start8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_unsigned_max();
    test_signed_extremes();
    test_handshake();
    test_reset_midrun();
    test_exhaustive4();
    test_random8();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
